fetch_controller: RTL and testbench

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_controller_pkg.sv | 23 ++
 rtl/fetch_controller_if.sv | 28 ++
 rtl/fetch_pc_next.sv | 51 +++++
 rtl/fetch_controller.sv | 90 +++++++++
 tb/tb_fetch_controller.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/fetch_controller_pkg.sv
// Shared definitions for the fetch controller: FSM state encoding,
// word size and the default instruction memory size.
package fetch_controller_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DONE  = 2'd2,
    S_ERROR = 2'd3
  } fetch_state_e;

  localparam int WORD_BYTES         = 4;
  localparam int IMEM_BYTES_DEFAULT = 84;

  // A redirect target is usable only if it is word aligned and addresses
  // an instruction that lies completely inside the instruction memory.
  function automatic logic target_ok(input logic [31:0] target,
                                     input logic [31:0] imem_bytes);
    return (target[1:0] == 2'b00) &&
           (target <= imem_bytes - 32'(WORD_BYTES));
  endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Control and status bundle between a sequencer (master) and the
// fetch controller (slave).
interface fetch_controller_if;

  logic        start;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        done;
  logic        err;
  logic [31:0] instr_count;

  modport master (
    output start, stall, branch_taken, branch_target, jump, jump_target,
    input  pc, pc_plus4, fetch_valid, done, err, instr_count
  );

  modport slave (
    input  start, stall, branch_taken, branch_target, jump, jump_target,
    output pc, pc_plus4, fetch_valid, done, err, instr_count
  );

endinterface

// File: rtl/fetch_pc_next.sv
// Combinational next-PC selection with redirect target checking.
// Priority: stall (hold) > jump > branch_taken > sequential pc+4.
module fetch_pc_next
  import fetch_controller_pkg::*;
#(
  parameter int IMEM_BYTES = IMEM_BYTES_DEFAULT
) (
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] next_pc,
  output logic [31:0] pc_plus4,
  output logic        bad_target,
  output logic        seq_end
);

  logic        redirect;
  logic [31:0] target;

  // Pick the redirect source, flag bad targets and detect the end of memory
  always_comb begin
    pc_plus4   = pc + 32'(WORD_BYTES);
    redirect   = 1'b0;
    target     = pc_plus4;
    next_pc    = pc;
    bad_target = 1'b0;
    seq_end    = 1'b0;
    if (!stall) begin
      if (jump) begin
        redirect = 1'b1;
        target   = jump_target;
      end else if (branch_taken) begin
        redirect = 1'b1;
        target   = branch_target;
      end
      if (redirect) begin
        bad_target = !target_ok(target, 32'(IMEM_BYTES));
        next_pc    = bad_target ? pc : target;
      end else if (pc_plus4 >= 32'(IMEM_BYTES)) begin
        seq_end = 1'b1;
        next_pc = pc;
      end else begin
        next_pc = pc_plus4;
      end
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: walks the PC through instruction memory,
// follows jumps and taken branches, counts retired fetches and stops in
// DONE at the end of memory or in ERROR on a bad redirect target.
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter int          IMEM_BYTES = IMEM_BYTES_DEFAULT,
  parameter logic [31:0] RESET_PC   = 32'd0
) (
  input logic               clk,
  input logic               rst,
  fetch_controller_if.slave bus
);

  fetch_state_e state_q, state_n;
  logic [31:0]  pc_q, pc_n;
  logic [31:0]  count_q, count_n;
  logic [31:0]  next_pc;
  logic [31:0]  pc_plus4;
  logic         bad_target;
  logic         seq_end;

  fetch_pc_next #(
    .IMEM_BYTES (IMEM_BYTES)
  ) u_pc_next (
    .pc            (pc_q),
    .stall         (bus.stall),
    .jump          (bus.jump),
    .jump_target   (bus.jump_target),
    .branch_taken  (bus.branch_taken),
    .branch_target (bus.branch_target),
    .next_pc       (next_pc),
    .pc_plus4      (pc_plus4),
    .bad_target    (bad_target),
    .seq_end       (seq_end)
  );

  // State, PC and retirement counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      count_q <= 32'd0;
    end else begin
      state_q <= state_n;
      pc_q    <= pc_n;
      count_q <= count_n;
    end
  end

  // Next-state logic: start (re)launches from any idle-like state, RUN retires
  always_comb begin
    state_n = state_q;
    pc_n    = pc_q;
    count_n = count_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (bus.start) begin
          state_n = S_RUN;
          pc_n    = RESET_PC;
          count_n = 32'd0;
        end
      end
      S_RUN: begin
        if (!bus.stall) begin
          count_n = count_q + 32'd1;
          pc_n    = next_pc;
          if (bad_target) begin
            state_n = S_ERROR;
          end else if (seq_end) begin
            state_n = S_DONE;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        pc_n    = RESET_PC;
        count_n = 32'd0;
      end
    endcase
  end

  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.instr_count = count_q;
  assign bus.fetch_valid = (state_q == S_RUN);
  assign bus.done        = (state_q == S_DONE);
  assign bus.err         = (state_q == S_ERROR);

endmodule

// File: tb/tb_fetch_controller.sv
// Directed self-checking bench for fetch_controller with hand-computed
// expectations for an 84-byte instruction memory starting at address 0.
module tb_fetch_controller;

  logic clk;
  logic rst;
  int   total_checks;
  int   bad_checks;

  fetch_controller_if bus ();

  fetch_controller #(
    .IMEM_BYTES (84),
    .RESET_PC   (32'd0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total_checks++;
    if (observed !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, clock one edge and settle just after it
  task automatic applyStimulus(input logic r, input logic st, input logic sl,
                               input logic jp, input logic [31:0] jt,
                               input logic br, input logic [31:0] bt);
    rst               = r;
    bus.start         = st;
    bus.stall         = sl;
    bus.jump          = jp;
    bus.jump_target   = jt;
    bus.branch_taken  = br;
    bus.branch_target = bt;
    @(posedge clk);
    #1;
  endtask

  // Check pc, counter and the three state flags together
  task automatic checkState(input string tag, input logic [31:0] epc,
                            input logic [31:0] ecnt, input logic ev,
                            input logic ed, input logic ee);
    checkOutput({tag, "_pc"}, bus.pc, epc);
    checkOutput({tag, "_cnt"}, bus.instr_count, ecnt);
    checkOutput({tag, "_valid"}, 32'(bus.fetch_valid), 32'(ev));
    checkOutput({tag, "_done"}, 32'(bus.done), 32'(ed));
    checkOutput({tag, "_err"}, 32'(bus.err), 32'(ee));
  endtask

  // Directed scenario sequence
  initial begin
    total_checks = 0;
    bad_checks   = 0;
    rst               = 1'b1;
    bus.start         = 1'b0;
    bus.stall         = 1'b0;
    bus.jump          = 1'b0;
    bus.jump_target   = 32'd0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 32'd0;

    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    checkState("reset", 32'd0, 32'd0, 0, 0, 0);

    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkState("idle_hold", 32'd0, 32'd0, 0, 0, 0);

    // Straight-line run through all 21 instructions
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 21; i++) begin
      checkOutput($sformatf("seq_pc%0d", i), bus.pc, 32'(4 * i));
      checkOutput($sformatf("seq_p4_%0d", i), bus.pc_plus4, 32'(4 * i + 4));
      checkOutput($sformatf("seq_cnt%0d", i), bus.instr_count, 32'(i));
      checkOutput($sformatf("seq_valid%0d", i), 32'(bus.fetch_valid), 32'd1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
    end
    checkState("seq_done", 32'd80, 32'd21, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkState("done_hold", 32'd80, 32'd21, 0, 1, 0);

    // Restart from DONE, then stall at pc=8 with a jump that must be ignored
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    checkState("restart", 32'd0, 32'd0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkState("pre_stall", 32'd8, 32'd2, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 1, 32'd40, 0, 0);
      checkState($sformatf("stall%0d", i), 32'd8, 32'd2, 1, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkState("resume", 32'd12, 32'd3, 1, 0, 0);

    // Jump beats branch, then a plain taken branch
    applyStimulus(0, 0, 0, 1, 32'd40, 1, 32'd20);
    checkState("jump_prio", 32'd40, 32'd4, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'd20);
    checkState("branch", 32'd20, 32'd5, 1, 0, 0);

    // Misaligned branch target
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h22);
    checkState("misalign", 32'd20, 32'd6, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkState("err_hold", 32'd20, 32'd6, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    checkState("err_restart", 32'd0, 32'd0, 1, 0, 0);

    // Out-of-range branch target, start ignored while running
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    checkState("start_in_run", 32'd4, 32'd1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'd84);
    checkState("out_range", 32'd4, 32'd2, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    checkState("range_restart", 32'd0, 32'd0, 1, 0, 0);

    // Reset mid-run at pc=44 wins over start and jump
    applyStimulus(0, 0, 0, 1, 32'd44, 0, 0);
    checkState("to44", 32'd44, 32'd1, 1, 0, 0);
    applyStimulus(1, 1, 0, 1, 32'd40, 0, 0);
    checkState("mid_reset", 32'd0, 32'd0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    checkState("rerun", 32'd0, 32'd0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkState("rerun_step", 32'd4, 32'd1, 1, 0, 0);

    // Jump to the last valid word, then redirect from it back to 0
    applyStimulus(0, 0, 0, 1, 32'd80, 0, 0);
    checkState("to80", 32'd80, 32'd2, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 32'd0, 0, 0);
    checkState("jump_last", 32'd0, 32'd3, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'd76);
    checkState("br76", 32'd76, 32'd4, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkState("seq80", 32'd80, 32'd5, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkState("end_again", 32'd80, 32'd6, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
